// File: rtl/cfa_frame_ctrl.sv
// Frame sequencer for the CFA demosaic path: launches the addressing logic, counts accepted
// pixels, flags complete 3x3 windows and traps a stalled address stream as a sticky error.
module cfa_frame_ctrl #(
  parameter int unsigned DIM_W   = 11,
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frameReq,
  input  logic [DIM_W-1:0] rowMaxIn,
  input  logic [DIM_W-1:0] colMaxIn,
  input  logic             sinkReady,
  input  logic             alReady,
  input  logic             alAddressValid,
  input  logic             clrErr,
  output logic             alStart,
  output logic [DIM_W-1:0] alRowMax,
  output logic [DIM_W-1:0] alColMax,
  output logic             alEn,
  output logic             frameAck,
  output logic             winValid,
  output logic [CNT_W-1:0] pixCount,
  output logic             busy,
  output logic             frameDone,
  output logic             err
);

  localparam int unsigned STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StDone,
    StError
  } state_e;

  state_e             state;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic [STALL_W-1:0] stall;
  logic               accept;
  logic               stall_cyc;
  logic               last_pix;

  // Backpressure gates the address stream directly; it never counts as a stall.
  assign alEn      = (state == StRun) && sinkReady;
  assign accept    = alEn && alAddressValid;
  assign stall_cyc = alEn && !alAddressValid;
  assign last_pix  = (row == alRowMax) && (col == alColMax);
  assign winValid  = accept && (row >= DIM_W'(2)) && (col >= DIM_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      alStart   <= 1'b0;
      frameAck  <= 1'b0;
      frameDone <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      alRowMax  <= '0;
      alColMax  <= '0;
      pixCount  <= '0;
      row       <= '0;
      col       <= '0;
      stall     <= '0;
    end else begin
      alStart   <= 1'b0;
      frameAck  <= 1'b0;
      frameDone <= 1'b0;
      unique case (state)
        StIdle: begin
          if (frameReq && alReady) begin
            state    <= StLaunch;
            alStart  <= 1'b1;
            frameAck <= 1'b1;
            busy     <= 1'b1;
            alRowMax <= rowMaxIn;
            alColMax <= colMaxIn;
            pixCount <= '0;
            row      <= '0;
            col      <= '0;
            stall    <= '0;
          end
        end
        StLaunch: state <= StRun;
        StRun: begin
          if (accept) begin
            // Saturate rather than wrap if the count ever exceeds the port width.
            if (pixCount != '1) pixCount <= pixCount + CNT_W'(1);
            stall <= '0;
            if (col == alColMax) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if (last_pix) begin
              state     <= StDone;
              frameDone <= 1'b1;
            end
          end else if (stall_cyc) begin
            stall <= stall + STALL_W'(1);
            if (stall == STALL_W'(TIMEOUT - 1)) begin
              state <= StError;
              err   <= 1'b1;
            end
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        StError: begin
          if (clrErr) begin
            state <= StIdle;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cfa_frame_ctrl.sv
// Randomized bench for cfa_frame_ctrl; expectations come from pixel-index arithmetic per frame.
module tb_cfa_frame_ctrl;

  localparam int unsigned DIM_W   = 11;
  localparam int unsigned CNT_W   = 22;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned NoStop  = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             frameReq;
  logic [DIM_W-1:0] rowMaxIn;
  logic [DIM_W-1:0] colMaxIn;
  logic             sinkReady;
  logic             alReady;
  logic             alAddressValid;
  logic             clrErr;
  logic             alStart;
  logic [DIM_W-1:0] alRowMax;
  logic [DIM_W-1:0] alColMax;
  logic             alEn;
  logic             frameAck;
  logic             winValid;
  logic [CNT_W-1:0] pixCount;
  logic             busy;
  logic             frameDone;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the frame in progress: latched limits, accepts so far, observed window pulses.
  int unsigned cur_r, cur_c, acc, obs_wins;

  always #5 clk = ~clk;

  cfa_frame_ctrl #(
    .DIM_W  (DIM_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frameReq      (frameReq),
    .rowMaxIn      (rowMaxIn),
    .colMaxIn      (colMaxIn),
    .sinkReady     (sinkReady),
    .alReady       (alReady),
    .alAddressValid(alAddressValid),
    .clrErr        (clrErr),
    .alStart       (alStart),
    .alRowMax      (alRowMax),
    .alColMax      (alColMax),
    .alEn          (alEn),
    .frameAck      (frameAck),
    .winValid      (winValid),
    .pixCount      (pixCount),
    .busy          (busy),
    .frameDone     (frameDone),
    .err           (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_frame(input int unsigned r, input int unsigned c, input bit hold);
    rowMaxIn       = DIM_W'(r);
    colMaxIn       = DIM_W'(c);
    frameReq       = 1'b1;
    alReady        = 1'b1;
    sinkReady      = 1'b1;
    alAddressValid = 1'b1;
    tick();
    frameReq = hold;
    rowMaxIn = DIM_W'($urandom);
    colMaxIn = DIM_W'($urandom);
    #1;
    check("launch_ack", frameAck, 1);
    check("launch_start", alStart, 1);
    check("launch_alen", alEn, 0);
    check("launch_busy", busy, 1);
    check("launch_rowmax", alRowMax, r);
    check("launch_colmax", alColMax, c);
    check("launch_pix_clear", pixCount, 0);
    cur_r    = r;
    cur_c    = c;
    acc      = 0;
    obs_wins = 0;
    tick();
  endtask

  // mode 0: always ready; 1: sinkReady toggles 1/0; 2: random ready and valid.
  task automatic run_frame(input int mode, input int unsigned stop, output bit finished);
    int unsigned total;
    bit          tog;
    total    = (cur_r + 1) * (cur_c + 1);
    tog      = 1'b1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit          acc_now, exp_win;
      int unsigned er, ec;
      case (mode)
        0: begin
          sinkReady      = 1'b1;
          alAddressValid = 1'b1;
        end
        1: begin
          sinkReady      = tog;
          tog            = ~tog;
          alAddressValid = 1'b1;
        end
        default: begin
          sinkReady      = ($urandom_range(0, 3) != 0);
          alAddressValid = ($urandom_range(0, 3) != 0);
        end
      endcase
      rowMaxIn = DIM_W'($urandom);
      colMaxIn = DIM_W'($urandom_range(0, 9));
      #1;
      acc_now = sinkReady && alAddressValid;
      er      = acc / (cur_c + 1);
      ec      = acc % (cur_c + 1);
      exp_win = acc_now && (er >= 2) && (ec >= 2);
      check("run_alen", alEn, sinkReady);
      check("run_win", winValid, exp_win);
      check("run_pix", pixCount, acc);
      check("run_busy", busy, 1);
      check("run_err", err, 0);
      check("run_ack", frameAck, 0);
      check("run_done", frameDone, 0);
      check("run_rowmax_held", alRowMax, cur_r);
      check("run_colmax_held", alColMax, cur_c);
      if (winValid === 1'b1) obs_wins++;
      if (acc_now) acc++;
      tick();
      if (acc == total) begin
        finished = 1'b1;
        return;
      end
      if (acc == stop) return;
    end
    check("run_budget", acc, total);
  endtask

  task automatic finish_frame();
    int unsigned total, exp_w;
    total          = (cur_r + 1) * (cur_c + 1);
    exp_w          = ((cur_r >= 2) ? cur_r - 1 : 0) * ((cur_c >= 2) ? cur_c - 1 : 0);
    sinkReady      = 1'b1;
    alAddressValid = 1'b1;
    #1;
    check("done_pulse", frameDone, 1);
    check("done_busy", busy, 1);
    check("done_alen", alEn, 0);
    check("done_win", winValid, 0);
    check("done_ack", frameAck, 0);
    check("done_pix", pixCount, total);
    check("win_total", obs_wins, exp_w);
    tick();
    #1;
    check("idle_done_clear", frameDone, 0);
    check("idle_busy", busy, 0);
    check("idle_pix_hold", pixCount, total);
    check("idle_alen", alEn, 0);
    check("idle_ack", frameAck, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          fin;
    int unsigned stall;

    rst            = 1'b1;
    frameReq       = 1'b1;
    alReady        = 1'b1;
    sinkReady      = 1'b1;
    alAddressValid = 1'b1;
    clrErr         = 1'b0;
    rowMaxIn       = DIM_W'(5);
    colMaxIn       = DIM_W'(5);
    @(negedge clk);
    tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_start", alStart, 0);
    check("rst_ack", frameAck, 0);
    check("rst_done", frameDone, 0);
    check("rst_alen", alEn, 0);
    check("rst_win", winValid, 0);
    check("rst_pix", pixCount, 0);
    check("rst_rowmax", alRowMax, 0);
    check("rst_colmax", alColMax, 0);

    // Request without an idle addressing unit is held off.
    rst     = 1'b0;
    alReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("noready_busy", busy, 0);
      check("noready_ack", frameAck, 0);
    end

    // 8x8 fully ready, then 8x8 with toggling backpressure.
    start_frame(7, 7, 1'b0);
    run_frame(0, NoStop, fin);
    finish_frame();
    start_frame(7, 7, 1'b0);
    run_frame(1, NoStop, fin);
    finish_frame();

    // Degenerate frames.
    start_frame(0, 0, 1'b0);
    run_frame(2, NoStop, fin);
    finish_frame();
    start_frame(1, 7, 1'b0);
    run_frame(2, NoStop, fin);
    finish_frame();

    // Request held high through the whole frame relaunches straight from IDLE.
    start_frame(3, 4, 1'b1);
    run_frame(2, NoStop, fin);
    finish_frame();
    start_frame(4, 3, 1'b0);
    run_frame(2, NoStop, fin);
    finish_frame();

    for (int i = 0; i < 3; i++) begin
      start_frame($urandom_range(0, 9), $urandom_range(0, 9), 1'b0);
      run_frame(2, NoStop, fin);
      finish_frame();
    end

    // Stall after 10 accepts; backpressure cycles must not count toward the timeout.
    start_frame(7, 7, 1'b0);
    run_frame(0, 10, fin);
    stall = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      sinkReady      = ($urandom_range(0, 3) != 0);
      alAddressValid = 1'b0;
      #1;
      check("stall_err", err, 0);
      check("stall_busy", busy, 1);
      check("stall_alen", alEn, sinkReady);
      check("stall_pix", pixCount, 10);
      if (sinkReady) stall++;
      tick();
      if (stall == TIMEOUT) break;
    end
    check("stall_budget", stall, TIMEOUT);
    sinkReady = 1'b1;
    #1;
    check("error_err", err, 1);
    check("error_busy", busy, 1);
    check("error_alen", alEn, 0);
    for (int i = 0; i < 3; i++) begin
      frameReq = 1'b1;
      tick();
      #1;
      check("error_sticky", err, 1);
      check("error_noack", frameAck, 0);
    end
    frameReq = 1'b0;
    clrErr   = 1'b1;
    tick();
    clrErr = 1'b0;
    #1;
    check("clr_err", err, 0);
    check("clr_busy", busy, 0);

    // Reset in the middle of a frame, then a clean relaunch.
    start_frame(7, 7, 1'b0);
    run_frame(2, 20, fin);
    rst            = 1'b1;
    frameReq       = 1'b1;
    sinkReady      = 1'b1;
    alAddressValid = 1'b1;
    tick();
    rst      = 1'b0;
    frameReq = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pix", pixCount, 0);
    check("midrst_alen", alEn, 0);
    check("midrst_rowmax", alRowMax, 0);
    check("midrst_ack", frameAck, 0);
    start_frame(7, 7, 1'b0);
    run_frame(2, NoStop, fin);
    finish_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
